// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_pkg                                                        |
// | Shared encodings and constants for the UART RX front end.          |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package uart_rx_pkg;

  // Receiver FSM encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    START  = S_START,
    DATA   = S_DATA,
    PARITY = S_PARITY,
    STOP   = S_STOP
  } rx_state_e;

  // Frame length in bit periods, start and stop bits included
  localparam int FRAME_BITS_NOPAR = 10;
  localparam int FRAME_BITS_PAR   = 11;

  // Supported oversample ratios
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // 2-of-3 vote over the mid-bit oversamples
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_sampler                                                    |
// | Line synchronizer, per-bit edge counter and 3-sample majority vote.|
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      rst_n,
  input  logic                      rx_in,
  input  logic                      start,
  input  logic                      active,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      rx_s,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic                      sampled_bit,
  output logic                      bit_done
);

  logic                      sync_q1;
  logic [2:0]                samples;
  logic [PRESCALE_WIDTH-1:0] half;
  logic [PRESCALE_WIDTH-1:0] last;

  // Counter arithmetic wraps modulo 2^PRESCALE_WIDTH, so any prescale value
  // (legal or not) still reaches its last edge within one counter period.
  assign half        = prescale >> 1;
  assign last        = prescale - PRESCALE_WIDTH'(1);
  assign sampled_bit = maj3(samples);
  assign bit_done    = active && (edge_cnt == last);

  // Two-flop synchronizer; the line idles high so reset loads ones
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync_q1 <= rx_in;
      rx_s    <= sync_q1;
    end
  end

  // Edge counter: start cycle is edge 0, so the next cycle is edge 1
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (start) begin
      edge_cnt <= PRESCALE_WIDTH'(1);
    end else if (!active || (edge_cnt == last)) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
    end
  end

  // Capture the three oversamples centred on the middle of the bit
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      samples <= '0;
    end else if (active) begin
      if (edge_cnt == half - PRESCALE_WIDTH'(1)) samples[0] <= rx_s;
      if (edge_cnt == half)                      samples[1] <= rx_s;
      if (edge_cnt == half + PRESCALE_WIDTH'(1)) samples[2] <= rx_s;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_frontend.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_frontend                                                   |
// | Oversampling UART receiver: frame FSM, shift register, parity and  |
// | stop checks, registered byte/strobe outputs.                       |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module uart_rx_frontend
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      rst_n,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     RX_P_DATA,
  output logic                      RX_D_VLD,
  output logic                      Parity_Error,
  output logic                      Stop_Error
);

  localparam int               BCW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0]   BC_LAST = BCW'(DATA_WIDTH - 1);

  rx_state_e                 state;
  rx_state_e                 next_state;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic [BCW-1:0]            bit_cnt;
  logic [DATA_WIDTH-1:0]     shift_reg;
  logic                      par_err;
  logic                      rx_s;
  logic                      sampled_bit;
  logic                      bit_done;
  logic                      start_det;
  logic                      active;

  assign start_det = (state == IDLE) && !rx_s;
  assign active    = (state != IDLE);

  uart_rx_sampler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_sampler (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .rx_in       (RX_IN),
    .start       (start_det),
    .active      (active),
    .prescale    (prescale_q),
    .rx_s        (rx_s),
    .edge_cnt    (),
    .sampled_bit (sampled_bit),
    .bit_done    (bit_done)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; every non-idle state advances only at a bit boundary
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_s) next_state = START;
      START:   if (bit_done) next_state = sampled_bit ? IDLE : DATA;
      DATA:    if (bit_done && (bit_cnt == BC_LAST)) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) next_state = STOP;
      STOP:    if (bit_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Frame datapath: config capture at start, LSB-first shift, parity check
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_err    <= 1'b0;
    end else begin
      if (start_det) begin
        prescale_q <= Prescale;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
        bit_cnt    <= '0;
        par_err    <= 1'b0;
      end
      if ((state == DATA) && bit_done) begin
        shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
        bit_cnt   <= bit_cnt + BCW'(1);
      end
      if ((state == PARITY) && bit_done) begin
        par_err <= (sampled_bit != ((^shift_reg) ^ par_typ_q));
      end
    end
  end

  // Frame-end outputs; strobes default low so each lasts one cycle
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      RX_P_DATA    <= '0;
      RX_D_VLD     <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      RX_D_VLD     <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      if ((state == STOP) && bit_done) begin
        Parity_Error <= par_err;
        Stop_Error   <= !sampled_bit;
        if (sampled_bit && !par_err) begin
          RX_P_DATA <= shift_reg;
          RX_D_VLD  <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_rx_frontend                                                |
// | Directed self-checking bench for uart_rx_frontend.                 |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_uart_rx_frontend;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       Parity_Error;
  logic       Stop_Error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;

  int         vld_n  = 0;
  int         perr_n = 0;
  int         serr_n = 0;
  int         vld_cyc [16];
  logic [7:0] vld_dat [16];
  int         perr_cyc = 0;
  int         serr_cyc = 0;

  int vb, pb, sb;

  uart_rx_frontend #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (6)
  ) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .RX_P_DATA    (RX_P_DATA),
    .RX_D_VLD     (RX_D_VLD),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error)
  );

  always #5 CLK = ~CLK;

  // Cycle counter
  always @(posedge CLK) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge
  always @(negedge CLK) begin
    if (RX_D_VLD) begin
      if (vld_n < 16) begin
        vld_cyc[vld_n] <= cyc;
        vld_dat[vld_n] <= RX_P_DATA;
      end
      vld_n <= vld_n + 1;
    end
    if (Parity_Error) begin
      perr_cyc <= cyc;
      perr_n   <= perr_n + 1;
    end
    if (Stop_Error) begin
      serr_cyc <= cyc;
      serr_n   <= serr_n + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    vb = vld_n;
    pb = perr_n;
    sb = serr_n;
  endtask

  // Drive one frame, one oversample per falling edge. flip_at inverts a
  // single oversample; abort_at pulses reset for one cycle and abandons
  // the frame. Frame offset j reaches the DUT as rx_s in cycle t0+j.
  task automatic send_frame(input logic [7:0] data, input int p, input logic par_en,
                            input logic par_bit, input logic stop_bit,
                            input int flip_at, input int abort_at);
    logic [10:0] bits;
    int          n;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
    if (par_en) begin
      bits[9]  = par_bit;
      bits[10] = stop_bit;
      n = 11;
    end else begin
      bits[9] = stop_bit;
      n = 10;
    end
    t0 = cyc + 2;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < p; k++) begin
        if (b * p + k == abort_at) begin
          rst_n = 1'b0;
          @(negedge CLK);
          rst_n = 1'b1;
          RX_IN = 1'b1;
          return;
        end
        RX_IN = (b * p + k == flip_at) ? ~bits[b] : bits[b];
        @(negedge CLK);
      end
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    RX_IN    = 1'b1;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("rst_data", RX_P_DATA, 8'h00);
    check_val("rst_vld", RX_D_VLD, 1'b0);
    check_val("rst_perr", Parity_Error, 1'b0);
    check_val("rst_serr", Stop_Error, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge CLK);

    // P=8, no parity, 0xAA
    snap();
    send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1, -1, -1);
    repeat (5) @(negedge CLK);
    check_val("aa_vld_cnt", vld_n - vb, 1);
    check_val("aa_latency", vld_cyc[vb] - t0, 80);
    check_val("aa_data", vld_dat[vb], 8'hAA);
    check_val("aa_hold", RX_P_DATA, 8'hAA);
    check_val("aa_perr", perr_n - pb, 0);
    check_val("aa_serr", serr_n - sb, 0);

    // P=16, even parity, good parity bit
    Prescale = 6'd16;
    PAR_EN   = 1'b1;
    PAR_TYP  = 1'b0;
    snap();
    send_frame(8'hBB, 16, 1'b1, 1'b0, 1'b1, -1, -1);
    repeat (5) @(negedge CLK);
    check_val("bb_vld_cnt", vld_n - vb, 1);
    check_val("bb_latency", vld_cyc[vb] - t0, 176);
    check_val("bb_data", vld_dat[vb], 8'hBB);

    // Same frame, wrong parity bit
    snap();
    send_frame(8'hBB, 16, 1'b1, 1'b1, 1'b1, -1, -1);
    repeat (5) @(negedge CLK);
    check_val("par_perr_cnt", perr_n - pb, 1);
    check_val("par_perr_lat", perr_cyc - t0, 176);
    check_val("par_vld_cnt", vld_n - vb, 0);
    check_val("par_hold", RX_P_DATA, 8'hBB);

    // P=8, stop bit low
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    snap();
    send_frame(8'hCC, 8, 1'b0, 1'b0, 1'b0, -1, -1);
    repeat (5) @(negedge CLK);
    check_val("stop_serr_cnt", serr_n - sb, 1);
    check_val("stop_serr_lat", serr_cyc - t0, 80);
    check_val("stop_vld_cnt", vld_n - vb, 0);
    check_val("stop_hold", RX_P_DATA, 8'hBB);

    // Two-cycle low glitch is rejected
    snap();
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (40) @(negedge CLK);
    check_val("glitch_strobes", (vld_n - vb) + (perr_n - pb) + (serr_n - sb), 0);

    // P=16, 0x55 with the mid sample of data bit 3 inverted
    Prescale = 6'd16;
    snap();
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1, 4 * 16 + 8, -1);
    repeat (5) @(negedge CLK);
    check_val("maj_vld_cnt", vld_n - vb, 1);
    check_val("maj_data", RX_P_DATA, 8'h55);

    // P=32, odd parity, two frames back to back
    Prescale = 6'd32;
    PAR_EN   = 1'b1;
    PAR_TYP  = 1'b1;
    snap();
    send_frame(8'hDD, 32, 1'b1, 1'b1, 1'b1, -1, -1);
    send_frame(8'h05, 32, 1'b1, 1'b1, 1'b1, -1, -1);
    repeat (5) @(negedge CLK);
    check_val("b2b_vld_cnt", vld_n - vb, 2);
    check_val("b2b_spacing", vld_cyc[vb + 1] - vld_cyc[vb], 352);
    check_val("b2b_data0", vld_dat[vb], 8'hDD);
    check_val("b2b_data1", vld_dat[vb + 1], 8'h05);
    check_val("b2b_perr", perr_n - pb, 0);

    // Reset pulse during data bit 4 of 0xAA
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    snap();
    send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1, -1, 5 * 8 + 4);
    check_val("mrst_data", RX_P_DATA, 8'h00);
    check_val("mrst_vld", RX_D_VLD, 1'b0);
    check_val("mrst_perr", Parity_Error, 1'b0);
    check_val("mrst_serr", Stop_Error, 1'b0);
    repeat (100) @(negedge CLK);
    check_val("mrst_strobes", (vld_n - vb) + (perr_n - pb) + (serr_n - sb), 0);
    snap();
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, -1, -1);
    repeat (5) @(negedge CLK);
    check_val("post_vld_cnt", vld_n - vb, 1);
    check_val("post_data", RX_P_DATA, 8'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
